bn_channel_sequencer: RTL and testbench

Sequencing controller for the batch-normalization stage. It accepts one feature-map activation per handshake in channel-interleaved order: all FILTERS channels of pixel 0, then pixel 1, and so on. For each activation it tracks the channel and pixel position and issues the matching address to the per-channel parameter memories (beta, gamma, moving mean, moving variance). It then presents each activation to the normalization datapath aligned with its parameter read data, and signals the end of the frame.

---
 rtl/bn_channel_sequencer_pkg.sv | 15 +
 rtl/bn_pos_counter.sv | 42 ++++
 rtl/bn_channel_sequencer.sv | 91 +++++++++
 tb/tb_bn_channel_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bn_channel_sequencer_pkg.sv
// Shared definitions for the batch-normalization stage: sequencer FSM encoding
// and default geometry constants also used by the normalization datapath.
package bn_channel_sequencer_pkg;

  localparam int unsigned BN_FLOAT_BIT = 8;
  localparam int unsigned BN_FILTERS   = 64;
  localparam int unsigned BN_IMG_SIZE  = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bn_state_t;

endpackage

// File: rtl/bn_pos_counter.sv
// Channel/pixel position counter for channel-interleaved activations.
// Flags the final element of the frame; wraps back to (0,0) after it.
module bn_pos_counter
  import bn_channel_sequencer_pkg::*;
#(
  parameter int unsigned FILTERS = BN_FILTERS,
  parameter int unsigned PIXELS  = BN_IMG_SIZE * BN_IMG_SIZE,
  localparam int unsigned CH_W   = $clog2(FILTERS),
  localparam int unsigned PIX_W  = $clog2(PIXELS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  output logic [CH_W-1:0] ch,
  output logic            last
);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(FILTERS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  logic [PIX_W-1:0] pix;
  logic             ch_wrap;

  assign ch_wrap = (ch == CH_LAST);
  assign last    = ch_wrap && (pix == PIX_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ch  <= '0;
      pix <= '0;
    end else if (advance) begin
      if (ch_wrap) begin
        ch  <= '0;
        pix <= (pix == PIX_LAST) ? '0 : pix + PIX_W'(1);
      end else begin
        ch <= ch + CH_W'(1);
      end
    end
  end

endmodule

// File: rtl/bn_channel_sequencer.sv
// Batch-normalization sequencer: tracks channel/pixel position of incoming
// activations, addresses the per-channel parameter memories and aligns output.
module bn_channel_sequencer
  import bn_channel_sequencer_pkg::*;
#(
  parameter int unsigned FLOAT_BIT = BN_FLOAT_BIT,
  parameter int unsigned FILTERS   = BN_FILTERS,
  parameter int unsigned IMG_SIZE  = BN_IMG_SIZE,
  localparam int unsigned PIXELS   = IMG_SIZE * IMG_SIZE,
  localparam int unsigned CH_W     = $clog2(FILTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [FLOAT_BIT-1:0] s_data,
  output logic                 param_en,
  output logic [CH_W-1:0]      param_addr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [FLOAT_BIT-1:0] m_data,
  output logic [CH_W-1:0]      m_ch,
  output logic                 m_last
);

  bn_state_t       state, state_nxt;
  logic            accept;
  logic            frame_start;
  logic            final_elem;
  logic [CH_W-1:0] ch_cnt;

  bn_pos_counter #(
    .FILTERS (FILTERS),
    .PIXELS  (PIXELS)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .clear   (frame_start),
    .advance (accept),
    .ch      (ch_cnt),
    .last    (final_elem)
  );

  // A stalled output register blocks new accepts, so the parameter memories
  // (enable low) keep presenting the data that matches m_data.
  assign s_ready     = (state == RUN) && (!m_valid || m_ready);
  assign accept      = s_valid && s_ready;
  assign frame_start = (state == IDLE) && start;
  assign param_en    = accept;
  assign param_addr  = ch_cnt;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && final_elem) state_nxt = DRAIN;
      DRAIN:   if (m_valid && m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == DRAIN) && m_valid && m_ready;
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_ch    <= ch_cnt;
        m_last  <= final_elem;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bn_channel_sequencer.sv
// Directed self-checking bench for bn_channel_sequencer with a 4-channel,
// 2x2-pixel frame (16 elements per frame).
module tb_bn_channel_sequencer;

  localparam int unsigned FB  = 8;
  localparam int unsigned F   = 4;
  localparam int unsigned IMG = 2;
  localparam int unsigned N   = F * IMG * IMG;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          s_valid;
  logic          s_ready;
  logic [FB-1:0] s_data;
  logic          param_en;
  logic [1:0]    param_addr;
  logic          m_valid;
  logic          m_ready;
  logic [FB-1:0] m_data;
  logic [1:0]    m_ch;
  logic          m_last;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bn_channel_sequencer #(
    .FLOAT_BIT (FB),
    .FILTERS   (F),
    .IMG_SIZE  (IMG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .param_en   (param_en),
    .param_addr (param_addr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_ch       (m_ch),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"},    32'(s_ready),    32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_param_en"},   32'(param_en),   32'd0);
    check({tag, "_param_addr"}, 32'(param_addr), 32'd0);
    check({tag, "_m_valid"},    32'(m_valid),    32'd0);
    check({tag, "_m_data"},     32'(m_data),     32'd0);
    check({tag, "_m_ch"},       32'(m_ch),       32'd0);
    check({tag, "_m_last"},     32'(m_last),     32'd0);
  endtask

  // Called just after a clock edge; leaves the FSM in RUN with an empty output.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy",    32'(busy),    32'd1);
    check("start_s_ready", 32'(s_ready), 32'd1);
  endtask

  // Offers one element for a single cycle (m_ready assumed high).
  task automatic send(input logic [FB-1:0] d, input int unsigned ch, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    check("s_ready",    32'(s_ready),    32'd1);
    check("param_en",   32'(param_en),   32'd1);
    check("param_addr", 32'(param_addr), 32'(ch));
    tick();
    s_valid = 1'b0;
    check("m_valid", 32'(m_valid), 32'd1);
    check("m_data",  32'(m_data),  32'(d));
    check("m_ch",    32'(m_ch),    32'(ch));
    check("m_last",  32'(m_last),  32'(last));
  endtask

  // After the final element's accept: drain, done pulse, then quiet.
  task automatic finish_frame(input logic back_to_back);
    check("drain_busy",    32'(busy),    32'd1);
    check("drain_s_ready", 32'(s_ready), 32'd0);
    check("drain_done",    32'(done),    32'd0);
    tick();
    check("done_pulse",   32'(done),    32'd1);
    check("done_busy",    32'(busy),    32'd0);
    check("done_m_valid", 32'(m_valid), 32'd0);
    if (!back_to_back) begin
      tick();
      check("done_width", 32'(done), 32'd0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");

    reset   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    tick();
    check("idle_s_ready",  32'(s_ready),  32'd0);
    check("idle_param_en", 32'(param_en), 32'd0);
    check("idle_m_valid",  32'(m_valid),  32'd0);
    s_valid = 1'b0;

    // Frame 1: contiguous, full throughput, data 0x00..0x0F.
    do_start();
    for (int unsigned k = 0; k < N; k++)
      send(FB'(k), k % F, k == N - 1);
    finish_frame(1'b1);

    // Frame 2: started in the done cycle; 5-cycle output stall after element 5
    // with a stray start that must not restart the counters.
    do_start();
    for (int unsigned k = 0; k < 6; k++)
      send(FB'(8'h40 + k), k % F, 1'b0);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h46;
    for (int unsigned c = 0; c < 5; c++) begin
      start = (c == 2);
      #1;
      check("stall_s_ready",  32'(s_ready),  32'd0);
      check("stall_param_en", 32'(param_en), 32'd0);
      tick();
      start = 1'b0;
      check("stall_m_valid", 32'(m_valid), 32'd1);
      check("stall_m_data",  32'(m_data),  32'h45);
      check("stall_m_ch",    32'(m_ch),    32'd1);
      check("stall_busy",    32'(busy),    32'd1);
    end
    m_ready = 1'b1;
    for (int unsigned k = 6; k < N; k++)
      send(FB'(8'h40 + k), k % F, k == N - 1);
    finish_frame(1'b0);

    // Frame 3: reset while element 10 is offered.
    do_start();
    for (int unsigned k = 0; k < 10; k++)
      send(FB'(8'h80 + k), k % F, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h8A;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    s_valid = 1'b0;
    check_idle_outputs("midreset");
    for (int unsigned c = 0; c < 4; c++) begin
      tick();
      check("midreset_no_done", 32'(done), 32'd0);
    end

    // Frame 4: restart after reset begins at channel 0 and completes normally.
    do_start();
    for (int unsigned k = 0; k < N; k++)
      send(FB'(8'hC0 + k), k % F, k == N - 1);
    finish_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
